// File: rtl/tinyrv1_mem_pkg.sv
// ============================================================================
// Module  : tinyrv1_mem_pkg
// Brief   : Shared request-type constants and response record for tinyrv1_mem
// Revision: 1.0
// ============================================================================
`default_nettype none

package tinyrv1_mem_pkg;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef struct packed {
      logic        val;
      logic [31:0] data;
   } mem_resp_t;

endpackage

`default_nettype wire

// File: rtl/mem_resp_delay.sv
// ============================================================================
// Module  : mem_resp_delay
// Brief   : Fixed-depth response pipeline; output data holds while idle
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_resp_delay
   import tinyrv1_mem_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  mem_resp_t entry,
   output mem_resp_t resp
);

   mem_resp_t r_pipe [LATENCY];
   mem_resp_t w_prev [LATENCY];

   for (genvar i = 0; i < LATENCY; i++) begin : g_prev
      if (i == 0) begin : g_head
         assign w_prev[i] = entry;
      end else begin : g_body
         assign w_prev[i] = r_pipe[i-1];
      end
   end

   // Only the last stage is visible, so only it needs to hold data on idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe <= '{default: '0};
      end else begin
         for (int i = 0; i < LATENCY - 1; i++) begin
            r_pipe[i] <= w_prev[i];
         end
         r_pipe[LATENCY-1].val <= w_prev[LATENCY-1].val;
         if (w_prev[LATENCY-1].val) begin
            r_pipe[LATENCY-1].data <= w_prev[LATENCY-1].data;
         end
      end
   end

   assign resp = r_pipe[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/tinyrv1_mem.sv
// ============================================================================
// Module  : tinyrv1_mem
// Brief   : Dual-port fixed-latency instruction/data memory with preload port
// Revision: 1.0
// ============================================================================
`default_nettype none

module tinyrv1_mem
   import tinyrv1_mem_pkg::*;
#(
   parameter int NUM_WORDS = 256,
   parameter int LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemreq_val,
   input  logic [31:0] imemreq_addr,
   output logic        imemresp_val,
   output logic [31:0] imemresp_data,
   input  logic        dmemreq_val,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   output logic        dmemresp_val,
   output logic [31:0] dmemresp_data,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        err
);

   localparam int AW = $clog2(NUM_WORDS);

   logic [31:0] r_mem [NUM_WORDS];

   logic [AW-1:0] w_iidx;
   logic [AW-1:0] w_didx;
   logic [AW-1:0] w_lidx;
   logic          w_dwrite;
   logic          w_misaligned;
   mem_resp_t     w_ientry;
   mem_resp_t     w_dentry;
   mem_resp_t     w_iresp;
   mem_resp_t     w_dresp;
   logic          w_unused;

   assign w_iidx   = imemreq_addr[AW+1:2];
   assign w_didx   = dmemreq_addr[AW+1:2];
   assign w_lidx   = ld_addr[AW+1:2];
   assign w_dwrite = dmemreq_val && (dmemreq_type == MEM_WRITE);

   assign w_misaligned = (imemreq_val && (imemreq_addr[1:0] != 2'b00))
                      || (dmemreq_val && (dmemreq_addr[1:0] != 2'b00));

   assign w_unused = ^{imemreq_addr[31:AW+2], dmemreq_addr[31:AW+2],
                       ld_addr[31:AW+2], ld_addr[1:0]};

   // Reads sample the array before this edge's writes land: read-before-write.
   always_comb begin
      w_ientry      = '0;
      w_ientry.val  = imemreq_val;
      if (imemreq_val) begin
         w_ientry.data = r_mem[w_iidx];
      end
      w_dentry      = '0;
      w_dentry.val  = dmemreq_val;
      if (dmemreq_val && (dmemreq_type == MEM_READ)) begin
         w_dentry.data = r_mem[w_didx];
      end
   end

   // The data write is issued last so it overrides a colliding preload.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         r_mem[w_lidx] <= ld_data;
      end
      if (!rst && w_dwrite) begin
         r_mem[w_didx] <= dmemreq_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (w_misaligned) begin
         err <= 1'b1;
      end
   end

   mem_resp_delay #(.LATENCY(LATENCY)) u_idelay (
      .clk   (clk),
      .rst   (rst),
      .entry (w_ientry),
      .resp  (w_iresp)
   );

   mem_resp_delay #(.LATENCY(LATENCY)) u_ddelay (
      .clk   (clk),
      .rst   (rst),
      .entry (w_dentry),
      .resp  (w_dresp)
   );

   assign imemresp_val  = w_iresp.val;
   assign imemresp_data = w_iresp.data;
   assign dmemresp_val  = w_dresp.val;
   assign dmemresp_data = w_dresp.data;

endmodule

`default_nettype wire

// File: tb/tb_tinyrv1_mem.sv
// ============================================================================
// Module  : tb_tinyrv1_mem
// Brief   : Directed bench: LATENCY=2 instance plus a LATENCY=3 reset instance
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tinyrv1_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst3;
   logic        imemreq_val;
   logic [31:0] imemreq_addr;
   logic        dmemreq_val;
   logic        dmemreq_type;
   logic [31:0] dmemreq_addr;
   logic [31:0] dmemreq_wdata;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;

   logic        ival, dval, err;
   logic [31:0] idata, ddata;
   logic        ival3, dval3, err3;
   logic [31:0] idata3, ddata3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tinyrv1_mem #(.NUM_WORDS(256), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr),
      .imemresp_val(ival), .imemresp_data(idata),
      .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type),
      .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
      .dmemresp_val(dval), .dmemresp_data(ddata),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .err(err)
   );

   tinyrv1_mem #(.NUM_WORDS(256), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst3),
      .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr),
      .imemresp_val(ival3), .imemresp_data(idata3),
      .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type),
      .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
      .dmemresp_val(dval3), .dmemresp_data(ddata3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .err(err3)
   );

   function automatic logic [31:0] img(input int j);
      return (j == 3) ? 32'h0050_0093 : (32'hA000_0000 | j);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; rst3 = 1'b1;
      imemreq_val = 1'b0; imemreq_addr = '0;
      dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      tick(); tick();
      check("rst_ival", ival, 0);
      check("rst_idata", idata, 0);
      check("rst_dval", dval, 0);
      check("rst_ddata", ddata, 0);
      check("rst_err", err, 0);
      rst = 1'b0; rst3 = 1'b0;

      for (int j = 0; j < 8; j++) begin
         ld_en = 1'b1; ld_addr = j * 4; ld_data = img(j);
         tick();
      end
      ld_en = 1'b0;

      // Fetch latency: visible exactly one cycle, then data holds
      imemreq_val = 1'b1; imemreq_addr = 32'h0C;
      tick();
      imemreq_val = 1'b0;
      check("fetch_early_val", ival, 0);
      tick();
      check("fetch_val", ival, 1);
      check("fetch_data", idata, 32'h0050_0093);
      tick();
      check("fetch_after_val", ival, 0);
      check("fetch_hold_data", idata, 32'h0050_0093);

      // Store then load
      dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h40; dmemreq_wdata = 32'hDEAD_BEEF;
      tick();
      dmemreq_type = 1'b0;
      tick();
      dmemreq_val = 1'b0;
      check("store_resp_val", dval, 1);
      check("store_resp_data", ddata, 0);
      tick();
      check("load_val", dval, 1);
      check("load_data", ddata, 32'hDEAD_BEEF);
      tick();
      check("load_after_val", dval, 0);

      // Fetch and data write to the same word in one cycle
      imemreq_val = 1'b1; imemreq_addr = 32'h40;
      dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h40; dmemreq_wdata = 32'h1234_5678;
      tick();
      imemreq_val = 1'b0; dmemreq_val = 1'b0;
      tick();
      check("conflict_ival", ival, 1);
      check("conflict_idata", idata, 32'hDEAD_BEEF);
      check("conflict_dval", dval, 1);
      check("conflict_ddata", ddata, 0);
      imemreq_val = 1'b1;
      tick();
      imemreq_val = 1'b0;
      tick();
      check("refetch_ival", ival, 1);
      check("refetch_idata", idata, 32'h1234_5678);

      // Streaming fetches
      for (int i = 0; i < 8; i++) begin
         imemreq_val = 1'b1; imemreq_addr = i * 4;
         tick();
         if (i > 0) begin
            check("stream_val", ival, 1);
            check("stream_data", idata, img(i - 1));
         end
      end
      imemreq_val = 1'b0;
      tick();
      check("stream_last_val", ival, 1);
      check("stream_last_data", idata, img(7));
      tick();
      check("stream_end_val", ival, 0);

      // Address wrap then misaligned access
      dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h400;
      tick();
      check("wrap_err_clear", err, 0);
      dmemreq_addr = 32'h402;
      tick();
      dmemreq_val = 1'b0;
      check("wrap_val", dval, 1);
      check("wrap_data", ddata, img(0));
      check("misalign_err", err, 1);
      tick();
      check("misalign_val", dval, 1);
      check("misalign_data", ddata, img(0));
      tick(); tick();
      check("err_sticky", err, 1);
      check("misalign_after_val", dval, 0);

      // Reset mid-flight on the LATENCY=3 instance
      imemreq_val = 1'b1; imemreq_addr = 32'h0C;
      tick();
      imemreq_val = 1'b0;
      tick();
      rst3 = 1'b1;
      #1;
      check("midrst_ival", ival3, 0);
      check("midrst_idata", idata3, 0);
      check("midrst_ddata", ddata3, 0);
      check("midrst_err", err3, 0);
      tick(); tick();
      rst3 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("midrst_no_resp", ival3, 0);
      end
      imemreq_val = 1'b1;
      tick();
      imemreq_val = 1'b0;
      tick();
      check("post_rst_early", ival3, 0);
      tick();
      check("post_rst_ival", ival3, 1);
      check("post_rst_idata", idata3, 32'h0050_0093);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
